inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 64'h0, first fetch address after reset.
REQ-003 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  one clock; reset asynchronous, active-low (reset=0 asserts).
REQ-005 SHALL have port redirect_valid  in  1  branch/jump/jr taken; replaces fetch stream.
REQ-006 SHALL have port redirect_pc  in  64  new fetch byte address.
REQ-007 SHALL have port imem_req_valid  out  1  fetch request offered.
REQ-008 SHALL have port imem_req_ready  in  1  memory accepts request.
REQ-009 SHALL have port imem_req_addr  out  64  fetch byte address, bits[1:0]=0.
REQ-010 SHALL have port imem_resp_valid  in  1  instruction word returned, in request order, >=1 cycle after acceptance.
REQ-011 SHALL have port imem_resp_data  in  32  instruction word.
REQ-012 SHALL have port out_valid  out  1  head entry presented to decode.
REQ-013 SHALL have port out_ready  in  1  decode consumes head.
REQ-014 SHALL have port out_inst / out_pc / out_pc4  out  32/64/64  head instruction, its address, address+4.
REQ-015 SHALL have port misalign  out  1  one-cycle pulse: redirect_pc[1:0]!=0.

Function
REQ-016 Request handshake: accepted when imem_req_valid & imem_req_ready; fetch_pc += 4 (64-bit wrap) on acceptance.
REQ-017 imem_req_valid SHALL be 1 only when queue occupancy + outstanding < DEPTH and no redirect this cycle.
REQ-018 imem_req_valid/imem_req_addr SHALL hold stable until accepted unless redirect occurs.
REQ-019 Response SHALL push {data, pc} into queue tail; pc taken from in-order pc tag FIFO of accepted requests.
REQ-020 Output handshake: pop when out_valid & out_ready; out_* driven combinationally from head entry.
REQ-021 Push and pop in same cycle SHALL both occur, occupancy unchanged, including when full.
REQ-022 Redirect SHALL in the same edge: empty queue, set fetch_pc=redirect_pc with bits[1:0] forced 0, set drop count = outstanding requests (including one accepted that cycle).
REQ-023 While drop count>0 each response SHALL be discarded and decrement drop count; never enqueued.
REQ-024 Redirect cycle: out_valid SHALL still reflect pre-flush head; pop that cycle SHALL not corrupt flush; response that cycle SHALL be dropped.
REQ-025 Redirect with misaligned redirect_pc SHALL pulse misalign for one cycle and still redirect.
REQ-026 Back-to-back redirects SHALL accumulate drop count correctly; latest redirect_pc wins.
REQ-027 Minimum latency: request accepted cycle N, response cycle N+1, out_valid cycle N+2.
REQ-028 Sustained throughput SHALL be one instruction per cycle with 1-cycle memory and out_ready=1.
REQ-029 Counters SHALL be wide enough for 0..DEPTH; no overflow possible by REQ-017.

Reset
REQ-030 Reset asserted SHALL immediately force: queue empty, outstanding=0, drop count=0, fetch_pc=RESET_PC.
REQ-031 During reset outputs: imem_req_valid=0, out_valid=0, misalign=0, out_inst=0, out_pc=0, out_pc4=0 when queue empty.
REQ-032 First request SHALL be offered the first cycle after reset deasserts, address RESET_PC.
REQ-033 Reset mid-operation SHALL discard in-flight responses; responses arriving after release without matching request SHALL be ignored.

Structure
REQ-034 DEPTH default, RESET_PC default and entry layout {pc[63:0], inst[31:0]} SHALL live in shared package cpu_pkg.
REQ-035 SHALL instantiate one sub-module sync_fifo (parameterised width/depth, flush input) for the queue; pc tag FIFO SHALL reuse it.
REQ-036 fetch_pc+4 and out_pc4 SHALL use the existing 64-bit alu in ADD mode.

Verification
REQ-037 Reset release, imem 1-cycle, out_ready=1 -> addresses 0,4,8,... one per cycle; out_pc=0 at cycle 2, out_pc4=4.
REQ-038 out_ready=0 for 10 cycles -> exactly 4 requests accepted, out_valid=1, imem_req_valid=0 thereafter; release -> pcs 0,4,8,12 in order.
REQ-039 Memory 3-cycle latency, 2 outstanding, redirect_pc=0x100 -> both stale responses dropped, next out_pc=0x100.
REQ-040 Redirect to 0x202 -> misalign pulses one cycle, next request addr 0x200.
REQ-041 Redirect same cycle as response and pop -> queue empty next cycle, no stale entry ever reaches out.
REQ-042 reset=0 asserted mid-stream with 3 entries queued -> out_valid=0 same cycle, refetch from RESET_PC after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch-queue defaults, queue entry layout, ALU opcodes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  // Default fetch-queue geometry and boot address.
  localparam int          IFQ_DEPTH    = 4;
  localparam logic [63:0] IFQ_RESET_PC = 64'h0;

  // One fetched instruction together with the byte address it came from.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ifq_entry_t;

  localparam int IFQ_ENTRY_W = $bits(ifq_entry_t);

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR
  } alu_op_t;

  // Instruction fetches are word granular; low two address bits are dropped.
  function automatic logic [63:0] align_word(input logic [63:0] addr);
    return {addr[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/alu.sv
// 64-bit integer ALU shared by the core; the fetch unit only uses ADD.
// Latency: purely combinational.
// Backpressure: none.
module alu
  import cpu_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  alu_op_t     op,
  output logic [63:0] y
);

  // Select the operation; unknown opcodes yield zero.
  always_comb begin
    y = '0;
    unique case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with synchronous flush; head is shown combinationally.
// Latency: a pushed word is visible at head the cycle after the push edge.
// Backpressure: push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  // Pointers and occupancy; flush discards everything, including a same-cycle push.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents need no reset because occupancy guards every read.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit: issues word fetches, queues returned words with their pc for decode.
// Latency: request accepted cycle N, response N+1, visible at out_* in cycle N+2.
// Backpressure: requests stop once queued + outstanding reaches DEPTH; out_ready stalls the head.
module inst_fetch_queue
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = IFQ_DEPTH,
  parameter logic [63:0] RESET_PC = IFQ_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [63:0] out_pc,
  output logic [63:0] out_pc4,
  output logic        misalign
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [63:0]   fetch_pc;
  logic [63:0]   fetch_pc_inc;
  logic [63:0]   head_pc4;
  logic [63:0]   tag_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] q_count;
  logic [CW-1:0] tag_count;
  logic [CW:0]   in_use;
  logic          req_fire;
  logic          resp_seen;
  logic          resp_live;
  logic          pop_fire;
  logic          q_empty;
  logic          q_full;
  logic          tag_empty;
  logic          tag_full;
  logic          unused_status;
  ifq_entry_t    push_entry;
  ifq_entry_t    head_entry;

  // Every slot is reserved at request time, so a returning word always has room.
  assign in_use         = {1'b0, q_count} + {1'b0, outstanding};
  assign imem_req_valid = reset & ~redirect_valid & (in_use < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // A response with nothing outstanding (e.g. left over from before a reset) is ignored.
  // Stale responses are counted off by drop_cnt; a redirect cycle also swallows its response.
  assign resp_seen       = imem_resp_valid & (outstanding != '0);
  assign resp_live       = resp_seen & (drop_cnt == '0) & ~redirect_valid & ~tag_empty;
  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(resp_seen);

  assign push_entry = '{pc: tag_pc, inst: imem_resp_data};
  assign pop_fire   = out_valid & out_ready;

  // Decode sees the head directly; an empty queue presents all zeros.
  assign out_valid = ~q_empty;
  assign out_inst  = q_empty ? 32'h0 : head_entry.inst;
  assign out_pc    = q_empty ? 64'h0 : head_entry.pc;
  assign out_pc4   = q_empty ? 64'h0 : head_pc4;

  assign misalign = reset & redirect_valid & (redirect_pc[1:0] != 2'b00);

  assign unused_status = ^{tag_count, tag_full, q_full};

  // pc of every live accepted request, in issue order; a redirect forgets them all.
  sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_tag_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (resp_live),
    .head      (tag_pc),
    .empty     (tag_empty),
    .full      (tag_full),
    .count     (tag_count)
  );

  // Instruction queue feeding decode.
  sync_fifo #(.WIDTH(IFQ_ENTRY_W), .DEPTH(DEPTH)) u_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (resp_live),
    .push_data (push_entry),
    .pop       (pop_fire),
    .head      (head_entry),
    .empty     (q_empty),
    .full      (q_full),
    .count     (q_count)
  );

  alu u_fetch_inc (
    .a  (fetch_pc),
    .b  (64'd4),
    .op (ALU_ADD),
    .y  (fetch_pc_inc)
  );

  alu u_head_pc4 (
    .a  (head_entry.pc),
    .b  (64'd4),
    .op (ALU_ADD),
    .y  (head_pc4)
  );

  // Fetch pointer, outstanding count and stale-response budget.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        fetch_pc <= align_word(redirect_pc);
        drop_cnt <= outstanding_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc_inc;
        if (resp_seen && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios then random traffic against a queue-based model.
// Latency: memory model returns words 1..3 cycles after acceptance, in order.
// Backpressure: imem_req_ready and out_ready are driven fixed or randomly.
module tb_inst_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clock;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic [63:0] out_pc4;
  logic        misalign;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock           (clock),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_inst        (out_inst),
    .out_pc          (out_pc),
    .out_pc4         (out_pc4),
    .misalign        (misalign)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc;
    int          due;
    bit          stale;
  } req_t;

  int          compared;
  int          mismatched;
  int          cyc;
  int          last_due;
  int          mem_lat;
  bit          rand_ready;
  bit          rand_oready;
  bit          oready_fixed;
  bit          spurious;
  req_t        inflight[$];
  logic [63:0] outq[$];
  logic [63:0] m_fetch_pc;
  int          obs_fires;
  int          obs_pops;
  logic [63:0] popped[$];

  function automatic logic [31:0] memfun(input logic [63:0] pc);
    return pc[31:0] ^ pc[63:32] ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check outputs, advance the model.
  task automatic tick(input bit rst_v, input bit rv, input logic [63:0] rpc);
    bit          resp_now;
    bit          exp_rv;
    bit          fire;
    bit          pop_ok;
    logic [63:0] hd;
    req_t        r;
    int          lat;
    int          due;
    @(negedge clock);
    reset          = rst_v;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    out_ready      = rand_oready ? 1'($urandom_range(0, 1)) : oready_fixed;
    resp_now       = rst_v && (inflight.size() > 0) && (inflight[0].due == cyc);
    imem_resp_valid = resp_now || (spurious && inflight.size() == 0);
    imem_resp_data  = resp_now ? memfun(inflight[0].pc) : 32'hdead_beef;
    #1;
    if (!rst_v) begin
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_misalign", misalign, 0);
      chk("rst_out_inst", out_inst, 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_pc4", out_pc4, 0);
      inflight.delete();
      outq.delete();
      m_fetch_pc = RESET_PC;
      last_due   = cyc;
    end else begin
      exp_rv = !rv && (outq.size() + inflight.size() < DEPTH);
      chk("req_valid", imem_req_valid, exp_rv);
      if (exp_rv) chk("req_addr", imem_req_addr, m_fetch_pc);
      chk("misalign", misalign, rv && (rpc[1:0] != 2'b00));
      chk("out_valid", out_valid, outq.size() > 0);
      hd = (outq.size() > 0) ? outq[0] : 64'h0;
      chk("out_pc", out_pc, hd);
      chk("out_pc4", out_pc4, (outq.size() > 0) ? hd + 64'd4 : 64'h0);
      chk("out_inst", out_inst, (outq.size() > 0) ? memfun(hd) : 32'h0);
      if (imem_req_valid && imem_req_ready) obs_fires++;
      if (out_valid && out_ready) begin
        obs_pops++;
        popped.push_back(out_pc);
      end
      fire   = exp_rv && imem_req_ready;
      pop_ok = (outq.size() > 0) && out_ready;
      if (resp_now) begin
        r = inflight.pop_front();
        if (!r.stale && !rv) outq.push_back(r.pc);
      end
      if (pop_ok) void'(outq.pop_front());
      if (rv) begin
        foreach (inflight[i]) inflight[i].stale = 1'b1;
        outq.delete();
        m_fetch_pc = {rpc[63:2], 2'b00};
      end
      if (fire) begin
        lat = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        r.pc    = m_fetch_pc;
        r.due   = due;
        r.stale = 1'b0;
        inflight.push_back(r);
        last_due   = due;
        m_fetch_pc = m_fetch_pc + 64'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    compared = 0; mismatched = 0; cyc = 0; last_due = -1;
    mem_lat = 1; rand_ready = 0; rand_oready = 0; oready_fixed = 1; spurious = 0;
    m_fetch_pc = RESET_PC; obs_fires = 0; obs_pops = 0;
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0; out_ready = 1'b0;

    // Reset, then a stray response in the first cycle after release must be ignored.
    repeat (3) tick(0, 0, 0);
    spurious = 1;
    tick(1, 0, 0);
    spurious = 0;
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, RESET_PC);
    tick(1, 0, 0);
    tick(1, 0, 0);
    chk("lat_out_pc", out_pc, 64'h0);
    chk("lat_out_pc4", out_pc4, 64'h4);
    repeat (2) tick(1, 0, 0);
    obs_pops = 0;
    repeat (20) tick(1, 0, 0);
    chk("throughput_pops", obs_pops, 20);

    // Redirect while a response and a pop land in the same cycle.
    tick(1, 1, 64'h400);
    tick(1, 0, 0);
    chk("redir_same_cycle_empty", out_valid, 0);
    repeat (6) tick(1, 0, 0);

    // Decode stalled for 10 cycles: exactly DEPTH requests, then in-order drain.
    oready_fixed = 0;
    repeat (2) tick(0, 0, 0);
    obs_fires = 0;
    repeat (10) tick(1, 0, 0);
    chk("stall_fires", obs_fires, 4);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_req_valid", imem_req_valid, 0);
    popped.delete();
    oready_fixed = 1;
    repeat (4) tick(1, 0, 0);
    chk("drain_count", popped.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < popped.size()) chk("drain_pc", popped[i], 64'(4 * i));

    // Three-cycle memory: stale words dropped after a redirect.
    mem_lat = 3;
    repeat (6) tick(1, 0, 0);
    tick(1, 1, 64'h100);
    popped.delete();
    for (int i = 0; i < 20 && popped.size() == 0; i++) tick(1, 0, 0);
    chk("redir_pop_seen", popped.size() != 0, 1);
    if (popped.size() != 0) chk("redir_first_pc", popped[0], 64'h100);

    // Misaligned redirect target.
    tick(1, 1, 64'h202);
    chk("misalign_pulse", misalign, 1);
    tick(1, 0, 0);
    chk("misalign_clear", misalign, 0);
    chk("realign_addr", imem_req_addr, 64'h200);
    repeat (4) tick(1, 0, 0);

    // Back-to-back redirects: the later target wins.
    tick(1, 1, 64'h300);
    tick(1, 1, 64'h500);
    popped.delete();
    for (int i = 0; i < 20 && popped.size() == 0; i++) tick(1, 0, 0);
    chk("b2b_pop_seen", popped.size() != 0, 1);
    if (popped.size() != 0) chk("b2b_first_pc", popped[0], 64'h500);

    // Reset with three entries queued.
    mem_lat = 1;
    oready_fixed = 0;
    for (int i = 0; i < 20 && outq.size() != 3; i++) tick(1, 0, 0);
    chk("three_queued", outq.size(), 3);
    tick(0, 0, 0);
    chk("midrst_out_valid", out_valid, 0);
    tick(0, 0, 0);
    oready_fixed = 1;
    tick(1, 0, 0);
    chk("refetch_addr", imem_req_addr, RESET_PC);
    repeat (5) tick(1, 0, 0);

    // Random traffic.
    mem_lat = 0;
    rand_ready = 1;
    rand_oready = 1;
    for (int i = 0; i < 700; i++) begin
      spurious = ($urandom_range(0, 9) == 0);
      tick($urandom_range(0, 99) != 0, $urandom_range(0, 19) == 0, {$urandom, $urandom});
    end
    spurious = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
